lab8_soc_keys_pio: RTL

Parametrised Avalon-MM input PIO for push-buttons and switches; the successor to the fixed 2-bit key input port.
- Synchronises and debounces WIDTH asynchronous inputs.
- Captures edges per bit, applies a per-bit interrupt mask and drives one level IRQ to the Nios II.
- Sits on the SoC Avalon bus beside the other PIO slaves. Read latency is fixed at 1 cycle.

---
 rtl/lab8_pio_pkg.sv | 17 +
 rtl/lab8_soc_keys_pio_if.sv | 22 ++
 rtl/lab8_pio_debounce_bit.sv | 59 +++++
 rtl/lab8_soc_keys_pio.sv | 94 +++++++++
 4 files changed

// File: rtl/lab8_pio_pkg.sv
// Shared constants for the keys/switches input PIO: bus widths, register
// addresses and edge-capture type encoding.
package lab8_pio_pkg;

    localparam int unsigned PIO_ADDR_W = 2;
    localparam int unsigned PIO_DATA_W = 32;

    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_RAW     = 2'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/lab8_soc_keys_pio_if.sv
// Avalon-MM slave bus of the input PIO, including its level interrupt.
interface lab8_soc_keys_pio_if;
    import lab8_pio_pkg::*;

    logic [PIO_ADDR_W-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [PIO_DATA_W-1:0] writedata;
    logic [PIO_DATA_W-1:0] readdata;
    logic                  irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/lab8_pio_debounce_bit.sv
// One input channel: flop-chain synchroniser followed by a stable-count
// debouncer. DEBOUNCE_CYCLES=0 makes stable follow sync_out every cycle.
module lab8_pio_debounce_bit #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_out,
    output logic stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign stable   = r_stable;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= 1'b0;
                end else begin
                    r_stable <= r_sync[SYNC_STAGES-1];
                end
            end
        end else begin : g_count
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

            logic [CNT_W-1:0] r_cnt;

            // Count consecutive cycles of disagreement; any agreement restarts.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync[SYNC_STAGES-1] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync[SYNC_STAGES-1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/lab8_soc_keys_pio.sv
// Parametrised Avalon-MM input PIO: per-bit synchronise/debounce, edge
// capture with write-1-to-clear, per-bit IRQ mask and 1-cycle registered reads.
module lab8_soc_keys_pio
    import lab8_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    lab8_soc_keys_pio_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port
);

    logic [WIDTH-1:0]      w_sync;
    logic [WIDTH-1:0]      w_stable;
    logic [WIDTH-1:0]      w_edge;
    logic [WIDTH-1:0]      w_wr_data;
    logic                  w_wr_en;
    logic [PIO_DATA_W-1:0] w_rd_mux;
    logic [WIDTH-1:0]      r_stable_d;
    logic [WIDTH-1:0]      r_edgecap;
    logic [WIDTH-1:0]      r_irqmask;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_chan
            lab8_pio_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .din      (in_port[g]),
                .sync_out (w_sync[g]),
                .stable   (w_stable[g])
            );
        end
    endgenerate

    always_comb begin
        w_edge = w_stable & ~r_stable_d;
        case (EDGE_TYPE)
            EDGE_FALLING: w_edge = ~w_stable & r_stable_d;
            EDGE_ANY:     w_edge = w_stable ^ r_stable_d;
            default:      w_edge = w_stable & ~r_stable_d;
        endcase
    end

    assign w_wr_en   = bus.chipselect & ~bus.write_n;
    assign w_wr_data = WIDTH'(bus.writedata);

    // A new edge in the same cycle as a clear of that bit keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
            r_edgecap  <= '0;
            r_irqmask  <= '0;
        end else begin
            r_stable_d <= w_stable;
            if (w_wr_en && bus.address == PIO_ADDR_EDGECAP) begin
                r_edgecap <= (r_edgecap & ~w_wr_data) | w_edge;
            end else begin
                r_edgecap <= r_edgecap | w_edge;
            end
            if (w_wr_en && bus.address == PIO_ADDR_IRQMASK) begin
                r_irqmask <= w_wr_data;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            PIO_ADDR_DATA:    w_rd_mux = PIO_DATA_W'(w_stable);
            PIO_ADDR_RAW:     w_rd_mux = PIO_DATA_W'(w_sync);
            PIO_ADDR_IRQMASK: w_rd_mux = PIO_DATA_W'(r_irqmask);
            PIO_ADDR_EDGECAP: w_rd_mux = PIO_DATA_W'(r_edgecap);
            default:          w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= w_rd_mux;
        end
    end

    assign bus.irq = |(r_edgecap & r_irqmask);

endmodule
